aes_dec_ctrl: RTL and testbench

Iterative AES-128 decryption sequencer. Accepts one ciphertext block over a valid/ready handshake and runs the full inverse cipher through one shared single-round decrypt datapath, 10 passes deep. Reads round keys by index from the expanded-key store, and returns the plaintext over a valid/ready handshake. Sits between the file/stream front end and the round datapath.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_dec_ctrl.sv | 96 +++++++++
 tb/tb_aes_dec_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared constants and encodings for the iterative AES-128 decrypt path.
// The controller and the round datapath both agree on the mode values here.
package aes_pkg;

    localparam int DW  = 128;
    localparam int NR  = 10;
    localparam int KIW = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_e;

    // ENTRY skips AddRoundKey/InvMixColumns: the first inverse round only shifts and substitutes.
    localparam logic DP_FULL  = 1'b0;
    localparam logic DP_ENTRY = 1'b1;

    localparam logic [KIW-1:0] KEY_IDX_LAST = KIW'(NR);

endpackage

// File: rtl/aes_dec_ctrl.sv
// Sequencer for AES-128 decryption: one block at a time through a shared
// single-round inverse datapath, with the first and last AddRoundKey done locally.
module aes_dec_ctrl
    import aes_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    input  logic           key_ready,
    output logic [KIW-1:0] key_idx,
    input  logic [DW-1:0]  key_data,
    output logic           key_lock,
    output logic [DW-1:0]  dp_state_in,
    output logic [DW-1:0]  dp_key,
    output logic           dp_mode,
    input  logic [DW-1:0]  dp_state_out,
    output logic           busy
);

    state_e         state_q, state_d;
    logic [KIW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]  st_q, st_d;
    logic           accept;

    assign in_ready  = (state_q == IDLE) & key_ready;
    assign accept    = in_ready & in_valid;
    assign out_valid = (state_q == DONE);
    assign out_data  = st_q;
    assign dp_key    = key_data;
    assign busy      = (state_q != IDLE);
    assign key_lock  = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        st_d        = st_q;
        key_idx     = KEY_IDX_LAST;
        dp_mode     = DP_FULL;
        dp_state_in = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    st_d    = in_data ^ key_data;
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                dp_state_in = st_q;
                dp_mode     = DP_ENTRY;
                cnt_d       = KIW'(NR - 1);
                state_d     = ROUND;
            end
            ROUND: begin
                // The datapath output is fed straight back so rounds run back-to-back.
                dp_state_in = dp_state_out;
                key_idx     = cnt_q;
                cnt_d       = cnt_q - 1'b1;
                if (cnt_q == KIW'(1)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                key_idx = '0;
                st_d    = dp_state_out ^ key_data;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Bench for aes_dec_ctrl: behavioural key store and round datapath around the DUT,
// scoreboard of expected plaintexts checked by an independent output monitor.
module tb_aes_dec_ctrl;

    localparam int DW  = 128;
    localparam int KIW = 4;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic           key_ready;
    logic [KIW-1:0] key_idx;
    logic [DW-1:0]  key_data;
    logic           key_lock;
    logic [DW-1:0]  dp_state_in;
    logic [DW-1:0]  dp_key;
    logic           dp_mode;
    logic [DW-1:0]  dp_state_out;
    logic           busy;

    always #5 clk = ~clk;

    aes_dec_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .key_ready(key_ready), .key_idx(key_idx), .key_data(key_data),
        .key_lock(key_lock), .dp_state_in(dp_state_in), .dp_key(dp_key),
        .dp_mode(dp_mode), .dp_state_out(dp_state_out), .busy(busy)
    );

    logic [7:0]   sbox     [256];
    logic [7:0]   inv_sbox [256];
    logic [127:0] rk       [16];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_txn    = 0;
    logic rand_or = 1'b0;

    typedef struct {
        logic [127:0] pt;
        int           acc;
    } exp_t;
    exp_t sb_q[$];

    // ---------------- GF(2^8) and AES primitives ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = gb(s, r + 4*((c - r + 4) % 4));
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox[gb(s, i)];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = gmul(a0,8'd14) ^ gmul(a1,8'd11) ^ gmul(a2,8'd13) ^ gmul(a3,8'd9);
            o[127-8*(4*c+1) -: 8] = gmul(a0,8'd9)  ^ gmul(a1,8'd14) ^ gmul(a2,8'd11) ^ gmul(a3,8'd13);
            o[127-8*(4*c+2) -: 8] = gmul(a0,8'd13) ^ gmul(a1,8'd9)  ^ gmul(a2,8'd14) ^ gmul(a3,8'd11);
            o[127-8*(4*c+3) -: 8] = gmul(a0,8'd11) ^ gmul(a1,8'd13) ^ gmul(a2,8'd9)  ^ gmul(a3,8'd14);
        end
        return o;
    endfunction

    // Behavioural round block: FULL = ARK, IMC, ISR, ISB; ENTRY = ISR, ISB.
    function automatic logic [127:0] dp_round(input logic [127:0] x, input logic [127:0] k, input logic m);
        if (m) return inv_sub_bytes(inv_shift_rows(x));
        return inv_sub_bytes(inv_shift_rows(inv_mix_columns(x ^ k)));
    endfunction

    // Reference: textbook FIPS-197 inverse cipher over the current key schedule.
    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk[10];
        for (int r = 9; r >= 1; r--) begin
            s = inv_shift_rows(s);
            s = inv_sub_bytes(s);
            s = s ^ rk[r];
            s = inv_mix_columns(s);
        end
        s = inv_shift_rows(s);
        s = inv_sub_bytes(s);
        return s ^ rk[0];
    endfunction

    task automatic build_tables;
        logic [7:0] inv, r1, r2, r3, r4, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
            s = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
            sbox[a] = s;
            inv_sbox[s] = 8'(a);
        end
    endtask

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int r = 11; r < 16; r++) rk[r] = '0;
    endtask

    // ---------------- environment models ----------------
    assign key_data = rk[key_idx];

    always @(posedge clk) dp_state_out <= dp_round(dp_state_in, dp_key, dp_mode);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    // ---------------- output monitor ----------------
    initial begin
        logic         prev_ov;
        logic [127:0] prev_od;
        prev_ov = 1'b0;
        prev_od = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out_valid got=%h required=no_output", out_data);
                    end else begin
                        chk("latency", 128'(cyc - sb_q[0].acc), 128'(12));
                    end
                end
                if (out_valid && prev_ov) chk("hold_data", out_data, prev_od);
                if (out_valid && out_ready && sb_q.size() != 0) begin
                    chk("plaintext", out_data, sb_q[0].pt);
                    $display("txn %0d accepted_cycle=%0d out_cycle=%0d pt=%h", n_txn, sb_q[0].acc, cyc, out_data);
                    n_txn++;
                    void'(sb_q.pop_front());
                end
                prev_ov = out_valid;
                prev_od = out_data;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_or) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [127:0] ct, input logic [127:0] pt, output int acc);
        acc = -1;
        in_valid = 1'b1;
        in_data  = ct;
        for (int n = 0; n < 200 && acc < 0; n++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                sb_q.push_back('{pt, cyc});
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        checks++;
        if (acc < 0) begin
            failures++;
            $display("FAIL accept_timeout got=no_accept required=accept");
        end
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got=%0d pending required=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, acc2, c, exp_idx;
        logic [127:0] ct;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; key_ready = 1'b1;
        build_tables();
        set_key(K1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_key_lock", 128'(key_lock), 128'(0));
        chk("rst_dp_mode", 128'(dp_mode), 128'(0));
        chk("rst_dp_state_in", dp_state_in, '0);
        chk("rst_key_idx", 128'(key_idx), 128'(10));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        rst = 1'b0;

        // FIPS-197 C.1 with key index / mode trace
        send(CT1, PT1, acc);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            exp_idx = (k == 1) ? 10 : ((k <= 10) ? 11 - k : 0);
            chk("key_idx_seq", 128'(key_idx), 128'(exp_idx));
            chk("dp_mode_seq", 128'(dp_mode), 128'(k == 1));
            chk("key_lock_busy", 128'(key_lock), 128'(1));
            if (k == 1) chk("entry_state_in", dp_state_in, CT1 ^ rk[10]);
        end
        drain();

        // FIPS-197 B
        @(posedge clk); #1;
        set_key(KB);
        send(CTB, PTB, acc);
        drain();

        // Backpressure, then accept right after release
        @(posedge clk); #1;
        set_key(K1);
        out_ready = 1'b0;
        send(CT1, PT1, acc);
        for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
        chk("bp_out_valid_seen", 128'(out_valid), 128'(1));
        in_valid = 1'b1;
        in_data  = CT1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 128'(in_ready), 128'(0));
            chk("bp_out_valid_held", 128'(out_valid), 128'(1));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        c = cyc;
        send(CT1, PT1, acc2);
        chk("bp_accept_next_cycle", 128'(acc2), 128'(c + 1));
        drain();

        // key_ready gating and key lock
        @(posedge clk); #1;
        key_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = CT1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("kr_in_ready_low", 128'(in_ready), 128'(0));
            chk("kr_key_lock_low", 128'(key_lock), 128'(0));
            chk("kr_busy_low", 128'(busy), 128'(0));
        end
        @(posedge clk); #1;
        key_ready = 1'b1;
        c = cyc;
        send(CT1, PT1, acc);
        chk("kr_accept_same_cycle", 128'(acc), 128'(c));
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("kr_key_lock_high", 128'(key_lock), 128'(1));
            if (k == 4) key_ready = 1'b0;
        end
        @(negedge clk);
        chk("kr_key_lock_released", 128'(key_lock), 128'(0));
        drain();
        key_ready = 1'b1;

        // Reset in mid-block, then a fresh block
        @(posedge clk); #1;
        send(CT1, PT1, acc);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        sb_q.delete();
        chk("mr_out_valid", 128'(out_valid), 128'(0));
        chk("mr_out_data", out_data, '0);
        chk("mr_busy", 128'(busy), 128'(0));
        chk("mr_key_lock", 128'(key_lock), 128'(0));
        chk("mr_dp_mode", 128'(dp_mode), 128'(0));
        chk("mr_dp_state_in", dp_state_in, '0);
        chk("mr_key_idx", 128'(key_idx), 128'(10));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        send(CT1, PT1, acc);
        drain();

        // Back-to-back C.1 then B, key swapped as soon as the lock drops
        @(posedge clk); #1;
        set_key(K1);
        send(CT1, PT1, acc);
        in_valid = 1'b1;
        in_data  = CTB;
        acc2 = -1;
        for (int n = 0; n < 40 && acc2 < 0; n++) begin
            @(negedge clk);
            if (!key_lock) begin
                set_key(KB);
                if (in_ready) begin
                    acc2 = cyc;
                    sb_q.push_back('{PTB, cyc});
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("b2b_spacing", 128'(acc2 - acc), 128'(13));
        drain();

        // Randomized blocks against the reference model
        rand_or = 1'b1;
        for (int blk = 0; blk < 16; blk++) begin
            if (blk % 4 == 0) begin
                drain();
                set_key({$urandom, $urandom, $urandom, $urandom});
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            ct = {$urandom, $urandom, $urandom, $urandom};
            send(ct, ref_decrypt(ct), acc);
        end
        rand_or = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
